// File: rtl/spi_ip_crc_phase_ctrl_pkg.sv
// Shared definitions for the SPI CRC phase controller: size codes, FSM states, bit counts.
package spi_ip_crc_phase_ctrl_pkg;

  localparam logic CRC_8  = 1'b0;
  localparam logic CRC_16 = 1'b1;

  localparam logic [3:0] CRC8_LAST_BIT  = 4'd7;
  localparam logic [3:0] CRC16_LAST_BIT = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_CRC_LOAD  = 3'd2,
    ST_CRC_SHIFT = 3'd3,
    ST_CHECK     = 3'd4
  } crc_state_e;

  // A CRC8 value is left-justified so the shifter always emits from bit 15.
  function automatic logic [15:0] crc_align(input logic size, input logic [15:0] value);
    return (size == CRC_16) ? value : {value[7:0], 8'h00};
  endfunction

endpackage

// File: rtl/spi_ip_crc_phase_ctrl_shifter.sv
// 16-bit load/shift register: parallel load, shifts left, MSB out, serial bit in at LSB.
module spi_ip_crc_shifter (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        shift_i,
  input  logic        bit_i,
  output logic [15:0] q_o
);

  logic [15:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = load_val_i;
    end else if (shift_i) begin
      sh_d = {sh_q[14:0], bit_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_q <= 16'h0000;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q_o = sh_q;

endmodule

// File: rtl/spi_ip_crc_phase_ctrl.sv
// CRC phase sequencer for an SPI transfer: gates engine enables, serialises TX CRC, checks RX CRC.
// Optional mismatch counter enabled by defining SPI_IP_CRC_ERR_CNT_EN.
module spi_ip_crc_phase_ctrl
  import spi_ip_crc_phase_ctrl_pkg::*;
#(
  parameter logic PARAM_TX_IDLE_BIT = 1'b0,
  parameter int   PARAM_ERR_CNT_W   = 8
) (
  input  logic                       cs_clk_i,
  input  logic                       cs_rst_n_i,
  input  logic                       cs_start_i,
  input  logic                       cs_abort_i,
  input  logic                       cs_bit_strobe_i,
  input  logic                       cs_frame_last_i,
  input  logic                       cs_tx_data_bit_i,
  input  logic                       cs_rx_bit_i,
  input  logic                       cs_crc_en_i,
  input  logic                       cs_crc_size_i,
  input  logic [15:0]                cs_crc_tx_value_i,
  input  logic [15:0]                cs_crc_rx_value_i,
  input  logic                       cs_err_clr_i,
  output logic                       cs_crc_init_o,
  output logic                       cs_crc_tx_en_o,
  output logic                       cs_crc_rx_en_o,
  output logic                       cs_tx_bit_o,
  output logic                       cs_crc_phase_o,
  output logic                       cs_crc_done_o,
  output logic                       cs_crc_err_o,
  output logic [PARAM_ERR_CNT_W-1:0] cs_err_cnt_o
);

  crc_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        sh_load, sh_shift;
  logic        chk_done, set_err, start_acc, mismatch;
  logic [15:0] tx_sh, rx_sh;

  assign mismatch = (cs_crc_size_i == CRC_16) ? (rx_sh != cs_crc_rx_value_i)
                                              : (rx_sh[7:0] != cs_crc_rx_value_i[7:0]);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    sh_load        = 1'b0;
    sh_shift       = 1'b0;
    chk_done       = 1'b0;
    set_err        = 1'b0;
    start_acc      = 1'b0;
    cs_crc_init_o  = 1'b0;
    cs_crc_tx_en_o = 1'b0;
    cs_crc_rx_en_o = 1'b0;
    cs_crc_phase_o = 1'b0;
    cs_tx_bit_o    = PARAM_TX_IDLE_BIT;
    case (state_q)
      ST_IDLE: begin
        if (cs_start_i) begin
          start_acc     = 1'b1;
          cs_crc_init_o = 1'b1;
          state_d       = ST_DATA;
        end
      end
      ST_DATA: begin
        cs_crc_tx_en_o = cs_bit_strobe_i;
        cs_crc_rx_en_o = cs_bit_strobe_i;
        cs_tx_bit_o    = cs_tx_data_bit_i;
        if (cs_bit_strobe_i && cs_frame_last_i) begin
          if (cs_crc_en_i) begin
            state_d = ST_CRC_LOAD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_CRC_LOAD: begin
        cs_crc_phase_o = 1'b1;
        cs_tx_bit_o    = (cs_crc_size_i == CRC_16) ? cs_crc_tx_value_i[15] : cs_crc_tx_value_i[7];
        sh_load        = 1'b1;
        cnt_d          = (cs_crc_size_i == CRC_16) ? CRC16_LAST_BIT : CRC8_LAST_BIT;
        state_d        = ST_CRC_SHIFT;
      end
      ST_CRC_SHIFT: begin
        cs_crc_phase_o = 1'b1;
        cs_tx_bit_o    = tx_sh[15];
        if (cs_bit_strobe_i) begin
          sh_shift = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_CHECK: begin
        chk_done = 1'b1;
        set_err  = mismatch;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything: no done, no error update, no register movement.
    if (cs_abort_i) begin
      state_d       = ST_IDLE;
      done_d        = 1'b0;
      sh_load       = 1'b0;
      sh_shift      = 1'b0;
      chk_done      = 1'b0;
      set_err       = 1'b0;
      start_acc     = 1'b0;
      cs_crc_init_o = 1'b0;
    end
    err_d = err_q;
    if (cs_err_clr_i || start_acc) err_d = 1'b0;
    if (set_err) err_d = 1'b1;
  end

  always_ff @(posedge cs_clk_i or negedge cs_rst_n_i) begin
    if (!cs_rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cs_crc_done_o = chk_done | done_q;
  assign cs_crc_err_o  = err_q;

  spi_ip_crc_shifter u_tx_sh (
    .clk_i      (cs_clk_i),
    .rst_n_i    (cs_rst_n_i),
    .load_i     (sh_load),
    .load_val_i (crc_align(cs_crc_size_i, cs_crc_tx_value_i)),
    .shift_i    (sh_shift),
    .bit_i      (1'b0),
    .q_o        (tx_sh)
  );

  // RX capture starts from zero so a CRC8 compare sees only the received byte.
  spi_ip_crc_shifter u_rx_sh (
    .clk_i      (cs_clk_i),
    .rst_n_i    (cs_rst_n_i),
    .load_i     (sh_load),
    .load_val_i (16'h0000),
    .shift_i    (sh_shift),
    .bit_i      (cs_rx_bit_i),
    .q_o        (rx_sh)
  );

`ifdef SPI_IP_CRC_ERR_CNT_EN
  logic [PARAM_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cs_err_clr_i) err_cnt_d = '0;
    if (set_err && (err_cnt_d != '1)) err_cnt_d = err_cnt_d + PARAM_ERR_CNT_W'(1);
  end

  always_ff @(posedge cs_clk_i or negedge cs_rst_n_i) begin
    if (!cs_rst_n_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cs_err_cnt_o = err_cnt_q;
`else
  assign cs_err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spi_ip_crc_phase_ctrl.sv
// Directed self-checking bench for spi_ip_crc_phase_ctrl (CRC16/CRC8 serialisation, check, abort, reset).
module tb_spi_ip_crc_phase_ctrl;

  localparam logic TX_IDLE = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, strobe, last, dbit, rxb, crc_en, size, clr;
  logic [15:0] txv, rxv;
  logic        init, txen, rxen, txbit, phase, done, err;
  logic [7:0]  errcnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spi_ip_crc_phase_ctrl #(.PARAM_TX_IDLE_BIT(TX_IDLE), .PARAM_ERR_CNT_W(8)) dut (
    .cs_clk_i(clk), .cs_rst_n_i(rst_n), .cs_start_i(start), .cs_abort_i(abort),
    .cs_bit_strobe_i(strobe), .cs_frame_last_i(last), .cs_tx_data_bit_i(dbit),
    .cs_rx_bit_i(rxb), .cs_crc_en_i(crc_en), .cs_crc_size_i(size),
    .cs_crc_tx_value_i(txv), .cs_crc_rx_value_i(rxv), .cs_err_clr_i(clr),
    .cs_crc_init_o(init), .cs_crc_tx_en_o(txen), .cs_crc_rx_en_o(rxen),
    .cs_tx_bit_o(txbit), .cs_crc_phase_o(phase), .cs_crc_done_o(done),
    .cs_crc_err_o(err), .cs_err_cnt_o(errcnt)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe_pulse(input logic d, input logic r, input logic l);
    strobe = 1'b1; dbit = d; rxb = r; last = l;
    tick();
    strobe = 1'b0; last = 1'b0;
  endtask

  task automatic run_crc8_bits(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) begin
      strobe_pulse(1'b0, bits[i], 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; strobe = 0; last = 0; dbit = 0; rxb = 0;
    crc_en = 0; size = 0; clr = 0; txv = 16'h0; rxv = 16'h0;
    #3;
    total++; if (init !== 1'b0) $display("FAIL reset_init got %b exp 0", init); else passed++;
    total++; if ({txen, rxen} !== 2'b00) $display("FAIL reset_en got %b exp 00", {txen, rxen}); else passed++;
    total++; if (txbit !== TX_IDLE) $display("FAIL reset_txbit got %b exp %b", txbit, TX_IDLE); else passed++;
    total++; if ({phase, done, err} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {phase, done, err}); else passed++;
    total++; if (errcnt !== 8'd0) $display("FAIL reset_errcnt got %0d exp 0", errcnt); else passed++;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_crc16_match();
    logic [15:0] exp_tx;
    exp_tx = 16'hA5C3;
    crc_en = 1; size = 1; txv = 16'hA5C3; rxv = 16'h1234;
    start = 1; #1;
    total++; if (init !== 1'b1) $display("FAIL c16_init got %b exp 1", init); else passed++;
    tick(); start = 0;
    strobe = 1; dbit = 1; #1;
    total++; if ({txen, rxen, txbit} !== 3'b111) $display("FAIL c16_data0 got %b exp 111", {txen, rxen, txbit}); else passed++;
    tick(); strobe = 0; tick();
    strobe = 1; dbit = 0; last = 1; #1;
    total++; if (txbit !== 1'b0) $display("FAIL c16_data1 got %b exp 0", txbit); else passed++;
    tick(); strobe = 0; last = 0;
    total++; if ({phase, txbit, txen} !== 3'b110) $display("FAIL c16_load got %b exp 110", {phase, txbit, txen}); else passed++;
    tick();
    for (int i = 15; i >= 0; i--) begin
      total++; if (txbit !== exp_tx[i]) $display("FAIL c16_bit%0d got %b exp %b", i, txbit, exp_tx[i]); else passed++;
      strobe_pulse(1'b0, rxv[i], 1'b0);
      total++; if (done !== (i == 0)) $display("FAIL c16_done_at%0d got %b exp %b", i, done, (i == 0)); else passed++;
      if (i > 0) tick();
    end
    tick();
    total++; if ({done, err, phase} !== 3'b000) $display("FAIL c16_end got %b exp 000", {done, err, phase}); else passed++;
    total++; if (txbit !== TX_IDLE) $display("FAIL c16_idle_txbit got %b exp %b", txbit, TX_IDLE); else passed++;
  endtask

  task automatic test_crc8_mismatch();
    logic [7:0] exp_tx, rx_bits;
    exp_tx = 8'hE7; rx_bits = 8'h3C;
    crc_en = 1; size = 0; txv = 16'h00E7; rxv = 16'hFF3D;
    start = 1; tick(); start = 0;
    strobe_pulse(1'b1, 1'b0, 1'b1);
    total++; if ({phase, txbit} !== 2'b11) $display("FAIL c8_load got %b exp 11", {phase, txbit}); else passed++;
    tick();
    for (int i = 7; i >= 0; i--) begin
      total++; if (txbit !== exp_tx[i]) $display("FAIL c8_bit%0d got %b exp %b", i, txbit, exp_tx[i]); else passed++;
      strobe_pulse(1'b0, rx_bits[i], 1'b0);
      total++; if (done !== (i == 0)) $display("FAIL c8_done_at%0d got %b exp %b", i, done, (i == 0)); else passed++;
      if (i > 0) tick();
    end
    tick();
    total++; if ({done, err} !== 2'b01) $display("FAIL c8_err got %b exp 01", {done, err}); else passed++;
`ifdef SPI_IP_CRC_ERR_CNT_EN
    total++; if (errcnt !== 8'd1) $display("FAIL c8_errcnt got %0d exp 1", errcnt); else passed++;
`endif
  endtask

  task automatic test_abort();
    crc_en = 1; size = 1; txv = 16'hA5C3;
    start = 1; #1;
    total++; if (init !== 1'b1) $display("FAIL ab_init got %b exp 1", init); else passed++;
    tick(); start = 0;
    total++; if (err !== 1'b0) $display("FAIL ab_start_clr got %b exp 0", err); else passed++;
`ifdef SPI_IP_CRC_ERR_CNT_EN
    total++; if (errcnt !== 8'd1) $display("FAIL ab_cnt_kept got %0d exp 1", errcnt); else passed++;
`endif
    strobe_pulse(1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      strobe_pulse(1'b0, 1'b0, 1'b0);
      tick();
    end
    total++; if ({phase, txbit} !== 2'b10) $display("FAIL ab_bit5 got %b exp 10", {phase, txbit}); else passed++;
    abort = 1; strobe = 1;
    tick(); abort = 0; strobe = 0;
    total++; if ({phase, done, err} !== 3'b000) $display("FAIL ab_idle got %b exp 000", {phase, done, err}); else passed++;
    total++; if (txbit !== TX_IDLE) $display("FAIL ab_txbit got %b exp %b", txbit, TX_IDLE); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL ab_nodone got %b exp 0", done); else passed++;
    start = 1; abort = 1; #1;
    total++; if (init !== 1'b0) $display("FAIL ab_beats_start got %b exp 0", init); else passed++;
    tick(); start = 0; abort = 0;
    strobe = 1; dbit = 1; #1;
    total++; if (txen !== 1'b0) $display("FAIL ab_stay_idle got %b exp 0", txen); else passed++;
    tick(); strobe = 0; tick();
  endtask

  task automatic test_err_clr();
    crc_en = 1; size = 0; txv = 16'h00E7; rxv = 16'hFF3D;
    start = 1; tick(); start = 0;
    strobe_pulse(1'b0, 1'b0, 1'b1); tick();
    run_crc8_bits(8'h3C);
    total++; if (err !== 1'b1) $display("FAIL clr_set got %b exp 1", err); else passed++;
`ifdef SPI_IP_CRC_ERR_CNT_EN
    total++; if (errcnt !== 8'd2) $display("FAIL clr_cnt2 got %0d exp 2", errcnt); else passed++;
`endif
    clr = 1; tick(); clr = 0;
    total++; if (err !== 1'b0) $display("FAIL clr_err got %b exp 0", err); else passed++;
`ifdef SPI_IP_CRC_ERR_CNT_EN
    total++; if (errcnt !== 8'd0) $display("FAIL clr_cnt got %0d exp 0", errcnt); else passed++;
`endif
    start = 1; tick(); start = 0;
    strobe_pulse(1'b0, 1'b0, 1'b1); tick();
    run_crc8_bits(8'h3D);
    total++; if (err !== 1'b0) $display("FAIL c8_upper_ignored got %b exp 0", err); else passed++;
  endtask

  task automatic test_nocrc();
    crc_en = 0; size = 1;
    start = 1; tick(); start = 0;
    strobe_pulse(1'b1, 1'b0, 1'b0); tick();
    strobe = 1; dbit = 0; last = 1; #1;
    total++; if ({txen, rxen} !== 2'b11) $display("FAIL nc_last_en got %b exp 11", {txen, rxen}); else passed++;
    tick(); strobe = 0; last = 0;
    total++; if ({done, phase, txen} !== 3'b100) $display("FAIL nc_done got %b exp 100", {done, phase, txen}); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL nc_done_pulse got %b exp 0", done); else passed++;
    strobe = 1; #1;
    total++; if ({txen, rxen} !== 2'b00) $display("FAIL nc_en_after got %b exp 00", {txen, rxen}); else passed++;
    tick(); strobe = 0; tick();
  endtask

  task automatic test_async_reset();
    crc_en = 1; size = 1; txv = 16'hA5C3; rxv = 16'h0000;
    start = 1; tick(); start = 0;
    strobe_pulse(1'b1, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      strobe_pulse(1'b0, 1'b0, 1'b0);
      tick();
    end
    total++; if (phase !== 1'b1) $display("FAIL ar_in_shift got %b exp 1", phase); else passed++;
    #2 rst_n = 1'b0; #1;
    total++; if ({phase, done, err, txen, rxen, init} !== 6'b0) $display("FAIL ar_outs got %b exp 000000", {phase, done, err, txen, rxen, init}); else passed++;
    total++; if (txbit !== TX_IDLE) $display("FAIL ar_txbit got %b exp %b", txbit, TX_IDLE); else passed++;
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++; if (phase !== 1'b0) $display("FAIL ar_post got %b exp 0", phase); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_crc16_match();
    test_crc8_mismatch();
    test_abort();
    test_err_clr();
    test_nocrc();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
